// File: rtl/uart_rx_byte.sv
// 8N1 UART receive front-end: synchronises rx, samples each bit at its centre and
// emits one byte per frame with a single-cycle po_flag (or frame_err on a bad stop bit).
module uart_rx_byte #(
    parameter int UART_BPS = 9600,
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       frame_err
);

    localparam int          BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam logic [12:0] BAUD_LAST    = 13'(BAUD_CNT_MAX - 1);
    localparam logic [12:0] BAUD_MID     = 13'(BAUD_CNT_MAX / 2 - 1);
    localparam logic [3:0]  LAST_BIT     = 4'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [12:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  po_data_q, po_data_d;
    logic        po_flag_q, po_flag_d;
    logic        frame_err_q, frame_err_d;
    logic        rx_s1_q, rx_s1_d;
    logic        rx_s2_q, rx_s2_d;
    logic        rx_s3_q, rx_s3_d;

    logic        start_edge;
    logic        mid_pulse;

    // Two flops for metastability, a third only to see the falling edge.
    always_comb begin
        rx_s1_d = rx;
        rx_s2_d = rx_s1_q;
        rx_s3_d = rx_s2_q;
    end

    assign start_edge = rx_s3_q & ~rx_s2_q;
    assign mid_pulse  = (state_q != IDLE) && (baud_cnt_q == BAUD_MID);

    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        po_data_d   = po_data_q;
        po_flag_d   = 1'b0;
        frame_err_d = 1'b0;

        if (state_q != IDLE) begin
            baud_cnt_d = (baud_cnt_q == BAUD_LAST) ? 13'd0 : baud_cnt_q + 13'd1;
        end

        case (state_q)
            IDLE: begin
                baud_cnt_d = 13'd0;
                bit_cnt_d  = 4'd0;
                if (start_edge) begin
                    state_d = START;
                end
            end
            START: begin
                if (mid_pulse) begin
                    if (!rx_s2_q) begin
                        state_d   = DATA;
                        bit_cnt_d = 4'd0;
                    end else begin
                        // Line went back high before mid start bit: treat as noise.
                        state_d    = IDLE;
                        baud_cnt_d = 13'd0;
                    end
                end
            end
            DATA: begin
                if (mid_pulse) begin
                    shift_d   = {rx_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (mid_pulse) begin
                    if (rx_s2_q) begin
                        po_data_d = shift_q;
                        po_flag_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    // Leaving at mid stop bit leaves half a bit to catch the next start edge.
                    state_d    = IDLE;
                    baud_cnt_d = 13'd0;
                    bit_cnt_d  = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            baud_cnt_q  <= 13'd0;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            po_data_q   <= 8'h00;
            po_flag_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_s3_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            po_data_q   <= po_data_d;
            po_flag_q   <= po_flag_d;
            frame_err_q <= frame_err_d;
            rx_s1_q     <= rx_s1_d;
            rx_s2_q     <= rx_s2_d;
            rx_s3_q     <= rx_s3_d;
        end
    end

    assign po_data   = po_data_q;
    assign po_flag   = po_flag_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Randomised bench for uart_rx_byte: frames are queued as expected events
// (byte or framing error at a fixed delay after the start edge) and compared every cycle.
module tb_uart_rx_byte;

    localparam int UART_BPS = 9600;
    localparam int CLK_FREQ = 480_000;
    localparam int P        = CLK_FREQ / UART_BPS;   // 50 cycles per bit
    localparam int MID      = P / 2 - 1;
    localparam int LAT      = 4 + MID + 9 * P;       // rx fall to po_flag

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       rx        = 1'b1;
    logic [7:0] po_data;
    logic       po_flag;
    logic       frame_err;

    uart_rx_byte #(
        .UART_BPS(UART_BPS),
        .CLK_FREQ(CLK_FREQ)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .rx       (rx),
        .po_data  (po_data),
        .po_flag  (po_flag),
        .frame_err(frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        bit         err;
    } ev_t;

    ev_t        evq[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         n_flags = 0;
    int         n_errs = 0;
    int         last_flag_cyc = 0;
    logic [7:0] model_data = 8'h00;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Per-cycle comparison of strobes and held byte against the event queue.
    logic exp_flag, exp_err;
    ev_t  ev;
    always @(negedge sys_clk) begin
        if (po_flag) begin
            n_flags++;
            last_flag_cyc = cyc;
        end
        if (frame_err) n_errs++;
        if (!sys_rst_n) begin
            evq.delete();
            model_data = 8'h00;
            chk({po_flag, frame_err, po_data} == 10'h000, "reset_outputs",
                {22'd0, po_flag, frame_err, po_data}, 32'd0);
        end else begin
            exp_flag = 1'b0;
            exp_err  = 1'b0;
            if (evq.size() > 0 && evq[0].cyc < cyc) begin
                ev = evq.pop_front();
                chk(1'b0, "missed_event", 32'(cyc), 32'(ev.cyc));
            end
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                ev = evq.pop_front();
                if (ev.err) exp_err = 1'b1;
                else begin
                    exp_flag   = 1'b1;
                    model_data = ev.data;
                end
            end
            chk({po_flag, frame_err, po_data} == {exp_flag, exp_err, model_data}, "strobe_data",
                {22'd0, po_flag, frame_err, po_data}, {22'd0, exp_flag, exp_err, model_data});
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input int per);
        ev_t e;
        e.cyc  = cyc + LAT;
        e.data = b;
        e.err  = !stop;
        evq.push_back(e);
        rx = 1'b0;
        wait_cyc(per);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(per);
        end
        rx = stop;
        wait_cyc(per);
    endtask

    initial begin
        #950_000;
        $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int         t0;
    int         f0;
    int         per;
    bit         stop;
    logic [7:0] b;

    initial begin
        sys_rst_n = 1'b0;
        rx        = 1'b1;
        wait_cyc(5);
        sys_rst_n = 1'b1;
        wait_cyc(3 * P);
        chk(po_data == 8'h00, "post_reset_data", 32'(po_data), 32'h00);

        // Single frame 0x55
        t0 = cyc;
        send_frame(8'h55, 1'b1, P);
        wait_cyc(P);
        chk(po_data == 8'h55, "single_data", 32'(po_data), 32'h55);
        chk(last_flag_cyc - t0 == 478, "single_latency", 32'(last_flag_cyc - t0), 32'd478);
        chk(n_flags == 1, "single_flag_count", 32'(n_flags), 32'd1);
        chk(n_errs == 0, "single_no_err", 32'(n_errs), 32'd0);

        // Glitch shorter than half a bit
        rx = 1'b0;
        wait_cyc(10);
        rx = 1'b1;
        wait_cyc(12 * P);
        chk(n_flags == 1 && n_errs == 0, "glitch_no_strobe", 32'(n_flags + n_errs), 32'd1);
        chk(po_data == 8'h55, "glitch_data_held", 32'(po_data), 32'h55);

        // Framing error, then a valid frame
        send_frame(8'hA3, 1'b0, P);
        rx = 1'b1;
        wait_cyc(P);
        chk(n_errs == 1, "ferr_count", 32'(n_errs), 32'd1);
        chk(n_flags == 1, "ferr_no_flag", 32'(n_flags), 32'd1);
        chk(po_data == 8'h55, "ferr_data_held", 32'(po_data), 32'h55);
        send_frame(8'h3C, 1'b1, P);
        wait_cyc(P);
        chk(po_data == 8'h3C, "after_ferr_data", 32'(po_data), 32'h3C);
        chk(n_flags == 2, "after_ferr_flag", 32'(n_flags), 32'd2);

        // Back-to-back stream, no idle gap
        f0 = n_flags;
        for (int i = 0; i < 60; i++) send_frame(8'(i), 1'b1, P);
        wait_cyc(P);
        chk(n_flags - f0 == 60, "stream_flag_count", 32'(n_flags - f0), 32'd60);
        chk(po_data == 8'd59, "stream_last_data", 32'(po_data), 32'd59);
        chk(n_errs == 1, "stream_no_err", 32'(n_errs), 32'd1);

        // Reset during bit 4 of 0xFF
        f0 = n_flags;
        rx = 1'b0;
        wait_cyc(P);
        rx = 1'b1;
        wait_cyc(4 * P + P / 2);
        sys_rst_n = 1'b0;
        wait_cyc(20);
        sys_rst_n = 1'b1;
        wait_cyc(8 * P);
        chk(po_data == 8'h00, "abort_data_reset", 32'(po_data), 32'h00);
        chk(n_flags == f0, "abort_no_flag", 32'(n_flags - f0), 32'd0);
        send_frame(8'h81, 1'b1, P);
        wait_cyc(P);
        chk(po_data == 8'h81, "post_abort_data", 32'(po_data), 32'h81);
        chk(n_flags == f0 + 1, "post_abort_flag", 32'(n_flags - f0), 32'd1);

        // Baud margin +-2%
        f0 = n_flags;
        send_frame(8'hC6, 1'b1, P - 1);
        wait_cyc(P);
        chk(po_data == 8'hC6 && n_flags == f0 + 1, "margin_fast", {24'd0, po_data}, 32'hC6);
        send_frame(8'hC6, 1'b1, P + 1);
        wait_cyc(P);
        chk(po_data == 8'hC6 && n_flags == f0 + 2, "margin_slow", {24'd0, po_data}, 32'hC6);

        // Random frames with random timing and occasional bad stop bits
        for (int i = 0; i < 20; i++) begin
            b    = 8'($urandom);
            per  = $urandom_range(P - 1, P + 1);
            stop = ($urandom_range(0, 5) != 0);
            send_frame(b, stop, per);
            if (!stop) begin
                rx = 1'b1;
                wait_cyc(2 + $urandom_range(0, P));
            end else if ($urandom_range(0, 1) == 1) begin
                wait_cyc($urandom_range(1, P));
            end
        end
        wait_cyc(2 * P);
        chk(evq.size() == 0, "events_pending", 32'(evq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
Serial receive front-end that feeds the image-RAM display stage. It deserialises 8N1 UART frames from the PC on the system clock and emits one byte per frame as po_data with a one-cycle po_flag strobe. The display stage uses that strobe directly as its RAM write enable and write-address increment. A 100x100 picture arrives as 10000 consecutive frames.

Parameters:
UART_BPS, 9600, line baud rate.
CLK_FREQ, 50_000_000, sys_clk frequency in Hz.
BAUD_CNT_MAX (derived, local), CLK_FREQ/UART_BPS = 5208, sys_clk cycles per bit.

Ports:
sys_clk  input  1  system clock, all logic on rising edge.
sys_rst_n  input  1  asynchronous active-low reset.
rx  input  1  asynchronous serial line, idle high.
po_data  output  8  received byte, LSB received first; held until the next valid frame.
po_flag  output  1  one-cycle strobe, high the cycle po_data updates.
frame_err  output  1  one-cycle strobe when the stop bit samples low.

Behaviour:
- Reset values: po_data=8'h00, po_flag=0, frame_err=0, state=IDLE, all counters=0, sync flops=1.
- Synchroniser: rx passes through 2 flops (rx_s1, rx_s2), then a third flop rx_s3 for edge detection.
- Start edge is rx_s3=1 && rx_s2=0, seen in IDLE only. Edges in other states are ignored.
- baud_cnt runs 0..BAUD_CNT_MAX-1 and wraps, outside IDLE only. It clears on entry to START.
- mid_pulse is asserted when baud_cnt == BAUD_CNT_MAX/2 - 1 (2603). All sampling uses rx_s2 on mid_pulse.
- FSM states and transitions:
  - IDLE -> START on start edge.
  - START: on mid_pulse, rx_s2=0 -> DATA with bit_cnt=0. rx_s2=1 -> IDLE; this is glitch rejection, with no strobe and po_data unchanged.
  - DATA: on each mid_pulse, shift rx_s2 into shift_reg[7] (right shift, LSB first) and increment bit_cnt. After the 8th sample (bit_cnt reaches 8) -> STOP.
  - STOP: on mid_pulse, rx_s2=1 -> po_data<=shift_reg, po_flag<=1 for exactly one cycle, then IDLE. rx_s2=0 -> frame_err<=1 for one cycle, po_data unchanged, then IDLE.
- Return to IDLE at the middle of the stop bit, so the next start edge is caught with no lost frames at full rate.
- Latency: po_flag rises 1 cycle after the stop-bit mid_pulse. That is about 9.5 bit periods plus 3 cycles after the start falling edge on rx.
- po_flag and frame_err are never high in the same cycle. Each fires at most once per frame.
- If rx is held low after a framing error, a new frame is not started until rx returns high and falls again.
- Reset asserted mid-frame aborts immediately to reset values. No strobe is produced for the partial frame.
- Counter widths: baud_cnt 13 bits, bit_cnt 4 bits.

Test Plan:
- Single frame: rx sends 0x55 at 5208 cycles/bit -> po_data=0x55, po_flag high exactly 1 cycle, about 49476 cycles after the start edge; frame_err stays 0.
- Glitch rejection: rx low for 1000 cycles, then high -> no po_flag, no frame_err, po_data keeps its previous value, FSM back in IDLE.
- Framing error: send 0xA3 with stop bit driven low -> frame_err 1-cycle pulse, po_flag stays 0, po_data unchanged; a following valid 0x3C then gives po_flag with po_data=0x3C.
- Back-to-back stream: 10000 frames with no idle gap, data = index[7:0] -> exactly 10000 po_flag pulses, each po_data matching in order, and no frame_err.
- Reset mid-frame: deassert sys_rst_n during bit 4 of 0xFF, release it, then send 0x81 -> outputs at reset values during reset, no strobe for the aborted frame, then po_data=0x81 with one po_flag.
- Baud margin: send 0xC6 with bit period 5208±2% (5104 and 5312 cycles) -> po_data=0xC6 with po_flag in both cases.
